match_sequencer: RTL and testbench
==================================

# match_sequencer

Match-level controller above the baccarat hand `statemachine`. It sequences a best-of-N match of hands by driving the hand state machine's active-low reset, and waits for its win lights. It tallies player, dealer and tie results, enforces a per-hand watchdog, and declares the match winner. It runs on `slow_clock`, so one hand step corresponds to one `slow_clock` edge.

## Interface
Parameters:
- `NUM_HANDS`, default 9: number of hands in a match (1..2^CNT_W−1).
- `CNT_W`, default 4: width of all tally counters.
- `TIMEOUT`, default 15: maximum PLAY cycles allowed before win lights appear.
- `SHOW_CYCLES`, default 2: cycles the result is held after a hand, before the next hand starts (≥1).

Ports:
- `slow_clock`, in, 1: the single clock, rising edge.
- `resetb`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begins a new match; sampled in IDLE, DONE and ERR.
- `abort`, in, 1: returns to IDLE; has priority over every other input.
- `player_win_light`, in, 1: from the hand state machine.
- `dealer_win_light`, in, 1: from the hand state machine.
- `hand_resetb`, out, 1: registered; drives the hand state machine's `resetb`.
- `hand_active`, out, 1: high in PLAY.
- `player_wins`, `dealer_wins`, `ties`, `hands_played`, out, CNT_W each: tally counters.
- `match_done`, out, 1: high in DONE.
- `match_winner`, out, 2: 00 none, 01 player, 10 dealer, 11 tie.
- `timeout_err`, out, 1: sticky while in ERR.

## Operation
- **Reset:** state IDLE. All outputs are 0, including `hand_resetb` = 0, which holds the hand state machine in reset.
- **IDLE:** `hand_resetb` = 0. If `start` = 1, go to CLEAR; clear all counters, `match_winner` and `timeout_err`.
- **CLEAR:** `hand_resetb` = 0 for exactly one cycle, then go to PLAY. On that edge set `hand_resetb` = 1 and `timer` = 0.
- **PLAY:** `timer` increments every cycle.
  - If either light is 1 at an edge, classify the result: both lights → `ties`+1; player light only → `player_wins`+1; dealer light only → `dealer_wins`+1.
  - Also `hands_played`+1, then go to SHOW.
  - If `timer` = TIMEOUT−1 and no light is seen, go to ERR and set `timeout_err` = 1.
- **SHOW:** `hand_resetb` stays 1, so the lights remain visible. After SHOW_CYCLES cycles:
  - if `hands_played` = NUM_HANDS, go to DONE;
  - otherwise go to CLEAR.
- **DONE:** `match_done` = 1 and `hand_resetb` = 0. `match_winner` is:
  - 01 if `player_wins` > `dealer_wins`;
  - 10 if `dealer_wins` > `player_wins`;
  - 11 if they are equal.
  - Ties do not count toward either side. `start` begins a new match via CLEAR, with counters cleared.
- **ERR:** `hand_resetb` = 0. Counters hold. `start` → CLEAR with everything cleared.
- **abort** in any state: go to IDLE on the next edge. `hand_resetb` = 0 and counters hold. `start` in the same cycle is ignored.
- **Counters:** CNT_W-bit unsigned. They cannot exceed NUM_HANDS by construction, so no wrap handling is needed.

## Timing
- All outputs are registered and update on the state-transition edge.
- `start` sampled at edge k → CLEAR from k. At edge k+1, PLAY is entered and `hand_resetb` rises.
- A light sampled at edge e → counters updated and SHOW entered at e.
- From a result at edge e, the next hand's `hand_resetb` low pulse starts at edge e+SHOW_CYCLES and lasts one cycle.
- The final result at edge e is followed by `match_done` = 1 from edge e+SHOW_CYCLES.
- Timeout: with no light, ERR is entered at the TIMEOUT-th edge after PLAY entry.
- Async `resetb` low clears all state immediately, with no clock edge required, including mid-hand.
- Lights seen in CLEAR or SHOW are ignored.

## Configuration
- `MATCH_EARLY_END_EN` defined: at the end of SHOW, go to DONE as soon as `player_wins` or `dealer_wins` > NUM_HANDS/2 (integer division), even if `hands_played` < NUM_HANDS.
- Undefined: every match plays exactly NUM_HANDS hands.

## Structure
- Shared package `baccarat_pkg`:
  - state enum (IDLE, CLEAR, PLAY, SHOW, DONE, ERR);
  - winner encodings WIN_NONE/WIN_PLAYER/WIN_DEALER/WIN_TIE.
- Sub-module `match_tally`: the four counters plus winner comparison, with clear and increment strobes.
- The FSM, timer and SHOW counter stay in `match_sequencer`.

## Test plan
1. Reset, then pulse `start`; the bench model raises both lights 5 cycles after `hand_resetb` rises → `ties` = 1, `hands_played` = 1, and `hand_resetb` low for one cycle 2 cycles later.
2. Nine hands with 5 player-only and 4 dealer-only results → `match_done` = 1, `match_winner` = 01, `player_wins` = 5, `dealer_wins` = 4, `hand_resetb` = 0.
3. No lights for 15 PLAY cycles → `timeout_err` = 1 and `hand_resetb` = 0, with counters held; `start` then clears everything and re-enters CLEAR.
4. `abort` asserted together with `start` during PLAY → IDLE on the next edge, `hand_active` = 0, counters unchanged.
5. Drop `resetb` asynchronously mid-SHOW with `player_wins` = 3 → all outputs 0 before the next clock edge.
6. With `MATCH_EARLY_END_EN` defined, 5 consecutive dealer wins → `match_done` = 1 after the 5th SHOW, `hands_played` = 5, `match_winner` = 10.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared definitions for the baccarat match controller: FSM state codes and
// match winner encodings.
package baccarat_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_PLAY  = 3'd2;
  localparam state_t ST_SHOW  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
  localparam state_t ST_ERR   = 3'd5;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_PLAYER = 2'b01;
  localparam logic [1:0] WIN_DEALER = 2'b10;
  localparam logic [1:0] WIN_TIE    = 2'b11;

endpackage

// File: rtl/match_sequencer_if.sv
// Match controller bus: match commands and hand lights in, hand control,
// tallies and match status out.
interface match_sequencer_if #(
  parameter int CNT_W = 4
);

  logic             start;
  logic             abort;
  logic             player_win_light;
  logic             dealer_win_light;
  logic             hand_resetb;
  logic             hand_active;
  logic [CNT_W-1:0] player_wins;
  logic [CNT_W-1:0] dealer_wins;
  logic [CNT_W-1:0] ties;
  logic [CNT_W-1:0] hands_played;
  logic             match_done;
  logic [1:0]       match_winner;
  logic             timeout_err;

  modport master (
    output start, abort, player_win_light, dealer_win_light,
    input  hand_resetb, hand_active, player_wins, dealer_wins, ties,
           hands_played, match_done, match_winner, timeout_err
  );

  modport slave (
    input  start, abort, player_win_light, dealer_win_light,
    output hand_resetb, hand_active, player_wins, dealer_wins, ties,
           hands_played, match_done, match_winner, timeout_err
  );

endinterface

// File: rtl/match_tally.sv
// Result counters for a match plus the registered winner decision, driven by
// clear/increment/latch strobes from the sequencer FSM.
module match_tally
  import baccarat_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             clear,
  input  logic             inc_player,
  input  logic             inc_dealer,
  input  logic             inc_tie,
  input  logic             inc_hand,
  input  logic             latch_winner,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties,
  output logic [CNT_W-1:0] hands_played,
  output logic [1:0]       match_winner
);

  // Ties are tallied but never weigh in the winner decision.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      player_wins  <= '0;
      dealer_wins  <= '0;
      ties         <= '0;
      hands_played <= '0;
      match_winner <= WIN_NONE;
    end else if (clear) begin
      player_wins  <= '0;
      dealer_wins  <= '0;
      ties         <= '0;
      hands_played <= '0;
      match_winner <= WIN_NONE;
    end else begin
      if (inc_player) player_wins  <= player_wins + 1'b1;
      if (inc_dealer) dealer_wins  <= dealer_wins + 1'b1;
      if (inc_tie)    ties         <= ties + 1'b1;
      if (inc_hand)   hands_played <= hands_played + 1'b1;
      if (latch_winner) begin
        if (player_wins > dealer_wins)
          match_winner <= WIN_PLAYER;
        else if (dealer_wins > player_wins)
          match_winner <= WIN_DEALER;
        else
          match_winner <= WIN_TIE;
      end
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// Best-of-N baccarat match controller sequencing the hand state machine.
// Optional MATCH_EARLY_END_EN ends the match once one side has a majority.
module match_sequencer
  import baccarat_pkg::*;
#(
  parameter int NUM_HANDS   = 9,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT     = 15,
  parameter int SHOW_CYCLES = 2
) (
  input logic          slow_clock,
  input logic          resetb,
  match_sequencer_if.slave bus
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SHOW_W  = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HANDS_C    = CNT_W'(NUM_HANDS);
`ifdef MATCH_EARLY_END_EN
  localparam logic [CNT_W-1:0]   HALF_C     = CNT_W'(NUM_HANDS / 2);
`endif

  state_t             state;
  state_t             next_state;
  logic [TIMER_W-1:0] timer;
  logic [SHOW_W-1:0]  show_cnt;

  logic hand_resetb_q;
  logic hand_active_q;
  logic match_done_q;
  logic timeout_err_q;

  logic tally_clear;
  logic inc_player;
  logic inc_dealer;
  logic inc_tie;
  logic inc_hand;
  logic latch_winner;
  logic any_light;
  logic match_over;

  logic [CNT_W-1:0] player_wins;
  logic [CNT_W-1:0] dealer_wins;
  logic [CNT_W-1:0] ties;
  logic [CNT_W-1:0] hands_played;
  logic [1:0]       match_winner;

  assign any_light = bus.player_win_light | bus.dealer_win_light;

`ifdef MATCH_EARLY_END_EN
  assign match_over = (hands_played == HANDS_C) ||
                      (player_wins > HALF_C) || (dealer_wins > HALF_C);
`else
  assign match_over = (hands_played == HANDS_C);
`endif

  // Next state and tally strobes; abort overrides everything, including start.
  always_comb begin
    next_state   = state;
    tally_clear  = 1'b0;
    inc_player   = 1'b0;
    inc_dealer   = 1'b0;
    inc_tie      = 1'b0;
    inc_hand     = 1'b0;
    latch_winner = 1'b0;
    if (bus.abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) begin
            next_state  = ST_CLEAR;
            tally_clear = 1'b1;
          end
        end
        ST_CLEAR: next_state = ST_PLAY;
        ST_PLAY: begin
          if (any_light) begin
            next_state = ST_SHOW;
            inc_hand   = 1'b1;
            inc_tie    = bus.player_win_light & bus.dealer_win_light;
            inc_player = bus.player_win_light & ~bus.dealer_win_light;
            inc_dealer = bus.dealer_win_light & ~bus.player_win_light;
          end else if (timer == TIMER_LAST) begin
            next_state = ST_ERR;
          end
        end
        ST_SHOW: begin
          if (show_cnt == SHOW_LAST) begin
            if (match_over) begin
              next_state   = ST_DONE;
              latch_winner = 1'b1;
            end else begin
              next_state = ST_CLEAR;
            end
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Status outputs are decoded from the next state so they change on the
  // same edge as the state they describe.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state         <= ST_IDLE;
      timer         <= '0;
      show_cnt      <= '0;
      hand_resetb_q <= 1'b0;
      hand_active_q <= 1'b0;
      match_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state         <= next_state;
      timer         <= (state == ST_PLAY && next_state == ST_PLAY) ? timer + 1'b1 : '0;
      show_cnt      <= (state == ST_SHOW && next_state == ST_SHOW) ? show_cnt + 1'b1 : '0;
      hand_resetb_q <= (next_state == ST_PLAY) || (next_state == ST_SHOW);
      hand_active_q <= (next_state == ST_PLAY);
      match_done_q  <= (next_state == ST_DONE);
      timeout_err_q <= (next_state == ST_ERR);
    end
  end

  match_tally #(
    .CNT_W (CNT_W)
  ) u_tally (
    .slow_clock   (slow_clock),
    .resetb       (resetb),
    .clear        (tally_clear),
    .inc_player   (inc_player),
    .inc_dealer   (inc_dealer),
    .inc_tie      (inc_tie),
    .inc_hand     (inc_hand),
    .latch_winner (latch_winner),
    .player_wins  (player_wins),
    .dealer_wins  (dealer_wins),
    .ties         (ties),
    .hands_played (hands_played),
    .match_winner (match_winner)
  );

  assign bus.hand_resetb  = hand_resetb_q;
  assign bus.hand_active  = hand_active_q;
  assign bus.match_done   = match_done_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.player_wins  = player_wins;
  assign bus.dealer_wins  = dealer_wins;
  assign bus.ties         = ties;
  assign bus.hands_played = hands_played;
  assign bus.match_winner = match_winner;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: a cycle table for the first hand and
// abort, then hand-written match, timeout, async reset and early-end sequences.
module tb_match_sequencer;

  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;

  int num_vectors     = 0;
  int num_miscompares = 0;

  match_sequencer_if #(.CNT_W(4)) bus ();

  match_sequencer #(
    .NUM_HANDS   (9),
    .CNT_W       (4),
    .TIMEOUT     (15),
    .SHOW_CYCLES (2)
  ) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus)
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct packed {
    logic       start;
    logic       abort;
    logic       pl;
    logic       dl;
    logic       hr;
    logic       ha;
    logic       done;
    logic       terr;
    logic [3:0] pw;
    logic [3:0] dw;
    logic [3:0] tw;
    logic [3:0] hp;
    logic [1:0] win;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [0:NV-1];

  function automatic vec_t mk(input logic s, a, p, d, hr, ha, dn, te,
                              input logic [3:0] pw, dw, tw, hp,
                              input logic [1:0] win);
    vec_t v;
    v.start = s;  v.abort = a; v.pl = p;  v.dl = d;
    v.hr = hr;    v.ha = ha;   v.done = dn; v.terr = te;
    v.pw = pw;    v.dw = dw;   v.tw = tw; v.hp = hp;
    v.win = win;
    return v;
  endfunction

  task automatic applyStimulus(input logic s, input logic a, input logic p, input logic d);
    @(negedge slow_clock);
    bus.start            = s;
    bus.abort            = a;
    bus.player_win_light = p;
    bus.dealer_win_light = d;
    @(posedge slow_clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    num_vectors++;
    if (actual !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".hand_resetb"},  bus.hand_resetb,  8'd0);
    checkOutput({tag, ".hand_active"},  bus.hand_active,  8'd0);
    checkOutput({tag, ".match_done"},   bus.match_done,   8'd0);
    checkOutput({tag, ".timeout_err"},  bus.timeout_err,  8'd0);
    checkOutput({tag, ".player_wins"},  bus.player_wins,  8'd0);
    checkOutput({tag, ".dealer_wins"},  bus.dealer_wins,  8'd0);
    checkOutput({tag, ".ties"},         bus.ties,         8'd0);
    checkOutput({tag, ".hands_played"}, bus.hands_played, 8'd0);
    checkOutput({tag, ".match_winner"}, bus.match_winner, 8'd0);
  endtask

  task automatic doReset();
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.player_win_light = 1'b0; bus.dealer_win_light = 1'b0;
    @(negedge slow_clock);
    resetb = 1'b0;
    repeat (2) @(posedge slow_clock);
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  initial begin
    int ep;
    int ed;
    logic p_hand;

    bus.start = 1'b0; bus.abort = 1'b0;
    bus.player_win_light = 1'b0; bus.dealer_win_light = 1'b0;

    //              s  a  p  d  hr ha dn te pw dw tw hp win
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    vecs[1]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    vecs[2]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    vecs[3]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    vecs[4]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    vecs[5]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    vecs[6]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2'b00);
    vecs[7]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2'b00);
    vecs[8]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00);
    vecs[9]  = mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 2'b00);
    vecs[10] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 2'b00);
    vecs[11] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00);
    vecs[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    vecs[14] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00);

    repeat (2) @(posedge slow_clock);
    #1;
    checkAllZero("reset");
    @(negedge slow_clock);
    resetb = 1'b1;

    // First hand ends in a tie; lights during SHOW/CLEAR must be ignored.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].pl, vecs[i].dl);
      checkOutput($sformatf("v%0d.hand_resetb", i),  bus.hand_resetb,  8'(vecs[i].hr));
      checkOutput($sformatf("v%0d.hand_active", i),  bus.hand_active,  8'(vecs[i].ha));
      checkOutput($sformatf("v%0d.match_done", i),   bus.match_done,   8'(vecs[i].done));
      checkOutput($sformatf("v%0d.timeout_err", i),  bus.timeout_err,  8'(vecs[i].terr));
      checkOutput($sformatf("v%0d.player_wins", i),  bus.player_wins,  8'(vecs[i].pw));
      checkOutput($sformatf("v%0d.dealer_wins", i),  bus.dealer_wins,  8'(vecs[i].dw));
      checkOutput($sformatf("v%0d.ties", i),         bus.ties,         8'(vecs[i].tw));
      checkOutput($sformatf("v%0d.hands_played", i), bus.hands_played, 8'(vecs[i].hp));
      checkOutput($sformatf("v%0d.match_winner", i), bus.match_winner, 8'(vecs[i].win));
    end

    // Full nine-hand match, alternating player and dealer, player first.
    doReset();
    applyStimulus(1, 0, 0, 0);
    ep = 0;
    ed = 0;
    for (int h = 0; h < 9; h++) begin
      p_hand = (h % 2 == 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput($sformatf("m%0d.hand_active", h), bus.hand_active, 8'd1);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, p_hand, ~p_hand);
      if (p_hand) ep++; else ed++;
      checkOutput($sformatf("m%0d.player_wins", h),  bus.player_wins,  8'(ep));
      checkOutput($sformatf("m%0d.dealer_wins", h),  bus.dealer_wins,  8'(ed));
      checkOutput($sformatf("m%0d.hands_played", h), bus.hands_played, 8'(h + 1));
      applyStimulus(0, 0, 0, 0);
      checkOutput($sformatf("m%0d.show_hold", h), bus.hand_resetb, 8'd1);
      applyStimulus(0, 0, 0, 0);
      if (h < 8) begin
        checkOutput($sformatf("m%0d.clear_pulse", h), bus.hand_resetb, 8'd0);
        checkOutput($sformatf("m%0d.match_done", h),  bus.match_done,  8'd0);
      end
    end
    checkOutput("match.match_done",   bus.match_done,   8'd1);
    checkOutput("match.match_winner", bus.match_winner, 8'b01);
    checkOutput("match.player_wins",  bus.player_wins,  8'd5);
    checkOutput("match.dealer_wins",  bus.dealer_wins,  8'd4);
    checkOutput("match.hand_resetb",  bus.hand_resetb,  8'd0);

    // Restart from DONE, one dealer hand, then a hand that times out.
    applyStimulus(1, 0, 0, 0);
    checkOutput("restart.player_wins",  bus.player_wins,  8'd0);
    checkOutput("restart.match_winner", bus.match_winner, 8'd0);
    checkOutput("restart.match_done",   bus.match_done,   8'd0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 1; i <= 14; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("to14.timeout_err", bus.timeout_err, 8'd0);
    checkOutput("to14.hand_active", bus.hand_active, 8'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("to15.timeout_err",  bus.timeout_err,  8'd1);
    checkOutput("to15.hand_resetb",  bus.hand_resetb,  8'd0);
    checkOutput("to15.hand_active",  bus.hand_active,  8'd0);
    checkOutput("to15.dealer_wins",  bus.dealer_wins,  8'd1);
    checkOutput("to15.hands_played", bus.hands_played, 8'd1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("err.timeout_err",  bus.timeout_err,  8'd1);
    checkOutput("err.ties",         bus.ties,         8'd0);
    checkOutput("err.hands_played", bus.hands_played, 8'd1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("errclr.timeout_err", bus.timeout_err, 8'd0);
    checkOutput("errclr.dealer_wins", bus.dealer_wins, 8'd0);
    checkOutput("errclr.hand_resetb", bus.hand_resetb, 8'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("errclr.play", bus.hand_resetb, 8'd1);

    // Three player wins, then async reset in the middle of SHOW.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1, 0);
      if (k < 2) begin
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
      end
    end
    checkOutput("pre_rst.player_wins", bus.player_wins, 8'd3);
    #2;
    resetb = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(negedge slow_clock);
    resetb = 1'b1;

    // Five straight dealer wins: early end only when the feature is built in.
    applyStimulus(1, 0, 0, 0);
    for (int h = 0; h < 5; h++) begin
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
    end
`ifdef MATCH_EARLY_END_EN
    checkOutput("early.match_done",   bus.match_done,   8'd1);
    checkOutput("early.hands_played", bus.hands_played, 8'd5);
    checkOutput("early.match_winner", bus.match_winner, 8'b10);
`else
    checkOutput("noearly.match_done",   bus.match_done,   8'd0);
    checkOutput("noearly.hands_played", bus.hands_played, 8'd5);
    checkOutput("noearly.hand_resetb",  bus.hand_resetb,  8'd0);
`endif
    checkOutput("five.dealer_wins", bus.dealer_wins, 8'd5);

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
